// File: rtl/cmn_pkg.sv
// Shared helpers for common payload-path blocks.
// Holds pointer sizing used by the FIFO and its pointer sub-module.
package cmn_pkg;

    // Index width for a DEPTH-entry array, never narrower than one bit.
    function automatic int ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/cmn_fifo_ptr.sv
// Wrap-at-DEPTH-1 incrementing pointer with enable and synchronous clear.
// Updates one cycle after en; clear wins over en; no backpressure of its own.
module cmn_fifo_ptr
    import cmn_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = ptr_w(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/cmn_vr_fifo.sv
// Valid/ready FIFO with occupancy/almost-full status and sync flush; 1-cycle latency,
// 0 when CMN_VR_FIFO_BYPASS_EN passes beats through an empty FIFO; s_rdy depends on registered state only.
module cmn_vr_fifo
    import cmn_pkg::*;
#(
    parameter type PLD_TYPE     = logic,
    parameter int  DEPTH        = 4,
    parameter int  AFULL_THRESH = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       s_vld,
    output logic                       s_rdy,
    input  PLD_TYPE                    s_pld,
    output logic                       m_vld,
    input  logic                       m_rdy,
    output PLD_TYPE                    m_pld,
    output logic [$clog2(DEPTH+1)-1:0] cnt,
    output logic                       afull
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    PLD_TYPE       mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          bypass;
    logic          push;
    logic          thru;
    logic          wr_en;
    logic          rd_en;

`ifdef CMN_VR_FIFO_BYPASS_EN
    assign bypass = (cnt == '0) && !flush;
`else
    assign bypass = 1'b0;
`endif

    // Full blocks input even when a pop is pending, keeping m_rdy off the s_rdy path.
    assign s_rdy = (cnt != CW'(DEPTH)) && !flush;
    assign m_vld = bypass ? s_vld : ((cnt != '0) && !flush);
    assign m_pld = bypass ? s_pld : mem[rd_ptr];

    assign push  = s_vld && s_rdy;
    assign thru  = bypass && s_vld && m_rdy;
    assign wr_en = push && !thru;
    assign rd_en = (cnt != '0) && !flush && m_rdy;

    assign afull = (cnt >= CW'(AFULL_THRESH));

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= s_pld;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    cmn_fifo_ptr #(.DEPTH(DEPTH), .W(PW)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .en    (wr_en),
        .ptr   (wr_ptr)
    );

    cmn_fifo_ptr #(.DEPTH(DEPTH), .W(PW)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .en    (rd_en),
        .ptr   (rd_ptr)
    );

endmodule

// File: tb/tb_cmn_vr_fifo.sv
// Directed bench for cmn_vr_fifo: a DEPTH=4 and a DEPTH=3 instance with byte payloads.
module tb_cmn_vr_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       f4 = 1'b0, sv4 = 1'b0, mr4 = 1'b0;
    logic [7:0] sp4 = '0;
    logic       sr4, mv4, af4;
    logic [7:0] mp4;
    logic [2:0] c4;

    logic       f3 = 1'b0, sv3 = 1'b0, mr3 = 1'b0;
    logic [7:0] sp3 = '0;
    logic       sr3, mv3, af3;
    logic [7:0] mp3;
    logic [1:0] c3;

    int checks = 0;
    int errors = 0;
    int rx, tx;
    logic [7:0] pat;

    always #5 clk = ~clk;

    cmn_vr_fifo #(.PLD_TYPE(logic [7:0]), .DEPTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .flush(f4),
        .s_vld(sv4), .s_rdy(sr4), .s_pld(sp4),
        .m_vld(mv4), .m_rdy(mr4), .m_pld(mp4),
        .cnt(c4), .afull(af4)
    );

    cmn_vr_fifo #(.PLD_TYPE(logic [7:0]), .DEPTH(3)) u3 (
        .clk(clk), .rst_n(rst_n), .flush(f3),
        .s_vld(sv3), .s_rdy(sr3), .s_pld(sp3),
        .m_vld(mv3), .m_rdy(mr3), .m_pld(mp3),
        .cnt(c3), .afull(af3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        rst_n = 1'b1;
        #1;
        chk("rst_s_rdy", sr4, 1);
        chk("rst_m_vld", mv4, 0);
        chk("rst_cnt", c4, 0);
        chk("rst_afull", af4, 0);
        chk("rst3_cnt", c3, 0);
        chk("rst3_m_vld", mv3, 0);
        tick();

        // Fill to DEPTH with the consumer stalled.
        mr4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sv4 = 1'b1;
            sp4 = 8'h0A + 8'(i);
            #1;
            chk("fill_s_rdy", sr4, 1);
            tick();
            chk("fill_cnt", c4, i + 1);
            chk("fill_afull", af4, (i + 1 >= 3) ? 1 : 0);
        end
        sv4 = 1'b0;
        #1;
        chk("full_s_rdy", sr4, 0);
        chk("full_m_vld", mv4, 1);

        // Drain in order.
        mr4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_m_vld", mv4, 1);
            chk("drain_pld", mp4, 8'h0A + i);
            tick();
            chk("drain_cnt", c4, 3 - i);
        end
        mr4 = 1'b0;
        #1;
        chk("drain_empty_m_vld", mv4, 0);
        chk("drain_afull", af4, 0);

        // Streaming: 20 beats, producer and consumer always active.
        rx = 0;
        for (int cy = 0; cy < 21; cy++) begin
            sv4 = (cy < 20);
            sp4 = 8'h10 + 8'(cy);
            mr4 = 1'b1;
            #1;
            if (mv4) begin
                chk("stream_pld", mp4, 8'h10 + rx);
                rx++;
            end
            tick();
            chk("stream_cnt_le1", (c4 <= 3'd1), 1);
        end
        sv4 = 1'b0;
        mr4 = 1'b0;
        chk("stream_rx", rx, 20);
        chk("stream_cnt_end", c4, 0);

        // Full with simultaneous pop: pop goes, push waits one cycle.
        for (int i = 0; i < 4; i++) begin
            sv4 = 1'b1;
            sp4 = 8'h20 + 8'(i);
            tick();
        end
        sv4 = 1'b1;
        sp4 = 8'h24;
        mr4 = 1'b1;
        #1;
        chk("fullpop_s_rdy", sr4, 0);
        chk("fullpop_pld", mp4, 8'h20);
        tick();
        chk("fullpop_cnt", c4, 3);
        mr4 = 1'b0;
        #1;
        chk("fullpop_s_rdy_next", sr4, 1);
        tick();
        chk("fullpop_cnt_end", c4, 4);
        sv4 = 1'b0;
        mr4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("fullpop_drain", mp4, 8'h21 + i);
            tick();
        end
        mr4 = 1'b0;
        chk("fullpop_drained", c4, 0);

        // Flush at cnt=3 with a beat offered in the same cycle.
        for (int i = 0; i < 3; i++) begin
            sv4 = 1'b1;
            sp4 = 8'h30 + 8'(i);
            tick();
        end
        chk("flush_pre_cnt", c4, 3);
        f4 = 1'b1;
        sv4 = 1'b1;
        sp4 = 8'h33;
        #1;
        chk("flush_s_rdy", sr4, 0);
        chk("flush_m_vld", mv4, 0);
        tick();
        f4 = 1'b0;
        sv4 = 1'b0;
        #1;
        chk("flush_cnt", c4, 0);
        chk("flush_m_vld_after", mv4, 0);
        sv4 = 1'b1;
        sp4 = 8'h34;
        tick();
        sv4 = 1'b0;
        #1;
        chk("flush_repush_cnt", c4, 1);
        chk("flush_repush_pld", mp4, 8'h34);
        mr4 = 1'b1;
        tick();
        mr4 = 1'b0;
        chk("flush_repush_pop", c4, 0);

        // Empty FIFO, beat offered with consumer ready.
        sv4 = 1'b1;
        sp4 = 8'h05;
        mr4 = 1'b1;
        #1;
`ifdef CMN_VR_FIFO_BYPASS_EN
        chk("byp_m_vld", mv4, 1);
        chk("byp_pld", mp4, 8'h05);
        tick();
        sv4 = 1'b0;
        chk("byp_cnt", c4, 0);
`else
        chk("nobyp_m_vld", mv4, 0);
        tick();
        sv4 = 1'b0;
        chk("nobyp_cnt", c4, 1);
        #1;
        chk("nobyp_m_vld_next", mv4, 1);
        chk("nobyp_pld", mp4, 8'h05);
        tick();
        chk("nobyp_cnt_end", c4, 0);
`endif
        mr4 = 1'b0;

        // DEPTH=3 wrap-around with a fixed stall pattern on m_rdy.
        pat = 8'b1011_0010;
        tx = 0;
        rx = 0;
        for (int cy = 0; cy < 40; cy++) begin
            sv3 = (tx < 10);
            sp3 = 8'h40 + 8'(tx);
            mr3 = pat[cy % 8];
            #1;
            if (sv3 && sr3) tx++;
            if (mv3 && mr3) begin
                chk("wrap_pld", mp3, 8'h40 + rx);
                rx++;
            end
            tick();
            chk("wrap_cnt_le3", (c3 <= 2'd3), 1);
        end
        sv3 = 1'b0;
        mr3 = 1'b0;
        chk("wrap_tx", tx, 10);
        chk("wrap_rx", rx, 10);
        chk("wrap_cnt_end", c3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmn_vr_fifo.md
# cmn_vr_fifo

Parameterised valid/ready FIFO that sits directly downstream of the forward register slice on common payload paths. It absorbs consumer backpressure over several cycles, so the producer-side slice keeps streaming while the consumer stalls. It uses the same handshake and payload typing as the slice. It also exposes occupancy and almost-full status for upstream flow control, and provides a synchronous flush.

## Interface
- PLD_TYPE, logic: payload type, any packed type.
- DEPTH, 4: number of entries, ≥2, need not be a power of two.
- AFULL_THRESH, DEPTH-1: `afull` asserts when count ≥ this value, 1..DEPTH.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear of all entries.
- s_vld  in  1  producer valid.
- s_rdy  out  1  FIFO can accept.
- s_pld  in  $bits(PLD_TYPE)  producer payload.
- m_vld  out  1  head entry valid.
- m_rdy  in  1  consumer ready.
- m_pld  out  $bits(PLD_TYPE)  head payload.
- cnt  out  $clog2(DEPTH+1)  current occupancy.
- afull  out  1  cnt ≥ AFULL_THRESH.

## Operation
- Push: s_vld && s_rdy. Pop: m_vld && m_rdy.
- s_rdy = (cnt != DEPTH) && !flush. It is a function of registered state only, with no combinational path from m_rdy.
- m_vld = (cnt != 0) && !flush. m_pld = entry at rd_ptr.
- Pointers wr_ptr and rd_ptr each wrap from DEPTH-1 to 0 and advance by one on push or pop respectively.
- cnt_next = cnt + push − pop. Simultaneous push and pop leaves cnt unchanged.
- When full, s_rdy is low even if a pop occurs in the same cycle. The cost is one bubble on the input after full, which is accepted.
- Flush: next cycle cnt=0 and wr_ptr=rd_ptr=0. Any s_vld or m_rdy in the flush cycle is ignored and nothing is transferred.
- Payload storage is written only on push and has no reset. Pointers and cnt are reset.
- Order is strict FIFO with no reordering or dropping.

## Timing
- Reset values: s_rdy=1, m_vld=0, cnt=0, afull=0 (AFULL_THRESH≥1). m_pld is don't-care while m_vld=0.
- Latency without bypass: 1 cycle. A push in cycle N is visible as m_vld in N+1 if the FIFO was empty.
- Sustained throughput is 1 push and 1 pop per cycle when 0<cnt<DEPTH.
- afull and cnt are registered-state outputs and update the cycle after the event.
- Asserting reset mid-operation empties the FIFO immediately, asynchronously.
- Flush takes priority over push and pop in the same cycle.

## Configuration
- CMN_VR_FIFO_BYPASS_EN defined:
  - When cnt==0 && !flush, m_vld=s_vld and m_pld=s_pld combinationally.
  - If m_rdy is also high, the beat passes through with zero latency and is not written; cnt is unchanged.
  - If m_rdy is low, the beat is written normally.
  - s_rdy is unchanged.
- CMN_VR_FIFO_BYPASS_EN undefined: there is no s→m combinational path and minimum latency is 1 cycle.

## Structure
- The shared cmn_pkg holds a pointer-width helper function. It returns $clog2(DEPTH) with a minimum of 1.
- Sub-module cmn_fifo_ptr is a wrap-at-DEPTH-1 incrementing pointer with enable and sync clear. It is instantiated for wr_ptr and rd_ptr.
- Storage is an array of PLD_TYPE inside cmn_vr_fifo.

## Test plan
- Fill and drain, DEPTH=4, m_rdy=0: push 0xA,0xB,0xC,0xD.
  - s_rdy drops after the 4th push; cnt=4; afull=1 from cnt=3.
  - Then m_rdy=1 pops 0xA..0xD in order, and cnt returns to 0.
- Streaming, s_vld=1 and m_rdy=1 continuously for 20 beats of an incrementing payload: all 20 beats are received in order with one output per cycle after the first; cnt stays ≤1.
- Wrap-around, DEPTH=3: 10 push/pop cycles with random m_rdy stalls. Pointers wrap past 2 and the data sequence is preserved.
- Full with simultaneous pop: at cnt=DEPTH, raise m_rdy and s_vld. The pop occurs with no push in that cycle; the push is accepted the next cycle and cnt ends at DEPTH.
- Flush with cnt=3 and s_vld=1 in the same cycle: next cycle cnt=0, m_vld=0, and the flush-cycle beat is not stored.
- Bypass, macro defined, empty FIFO, s_vld=1 with payload 0x5 and m_rdy=1: m_vld=1 and m_pld=0x5 in the same cycle, cnt stays 0. With the macro undefined, m_vld rises the next cycle.
